writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage of the x86 core: holds the EX→WB latches, retires one instruction per cycle into the GPR, segment, MMX and EFLAGS state, and sequences data-cache stores through a request/acknowledge handshake. It drives `WB_stall` back to EX while a store is outstanding. It also returns committed CF/AF to the ALU.

## Interface
- No parameters.
- `CLK` in 1: stage clock.
- `RST` in 1: synchronous, active-high reset.
- `WB_V_next`, `WB_NEIP_next[31:0]`, `WB_NCS_next[15:0]`, `WB_CONTROL_STORE_next[127:0]` in: EX→WB latch inputs.
- `WB_de_datasize_all_next[1:0]`, `WB_ex_ld_gpr1_wb_next`, `WB_ex_ld_gpr2_wb_next`, `WB_ex_dcache_write_wb_next`, `WB_de_flags_affected_wb_next[6:0]` in: EX→WB control latch inputs.
- `WB_RESULT_A_next`, `WB_RESULT_B_next`, `WB_RESULT_C_next`, `WB_FLAGS_next`, `WB_ADDRESS_next` in 32 each: EX→WB data latch inputs.
- `WB_RESULT_MM_next` in 64: EX→WB MMX result latch input.
- `WB_DR1_next`, `WB_DR2_next`, `WB_DR3_next` in 3 each: destination register latch inputs.
- `DC_WR_ACK` in 1: the data cache has accepted the store.
- `GPR_WE1/2/3` out 1, `GPR_DR1/2/3` out 3, `GPR_DATA1/2/3` out 32, `GPR_SIZE` out 2: GPR write ports fed from A/B/C.
- `SEG_WE` out 1, `SEG_DR` out 3, `SEG_DATA` out 16 (RESULT_A[15:0]).
- `MM_WE` out 1, `MM_DR` out 3, `MM_DATA` out 64.
- `DC_WR_REQ` out 1, `DC_WR_ADDR` out 32, `DC_WR_DATA` out 32, `DC_WR_SIZE` out 2: store request.
- `EFLAGS` out 32: committed flags.
- `EIP` out 32, `CS` out 16: committed next-instruction pointer.
- `RETIRE_CNT` out 32: count of retired instructions.
- `WB_stall` out 1: holds EX.
- `CF_dataforwarded`, `AF_dataforwarded` out 1: flags returned to EX.

## Operation
- Latches load all `*_next` inputs on every edge where `WB_stall`=0; they hold while `WB_stall`=1.
- `CS_LD_GPR3_WB`, `CS_LD_SEG_WB` and `CS_LD_MM_WB` are decoded from the latched control store.
- GPR1 takes DR1/RESULT_A, GPR2 takes DR2/RESULT_B, GPR3 takes DR3/RESULT_C. SEG and MM use DR1.
- **Commit** is a single-cycle event.
  - A non-store commits when the latch is valid and state=IDLE.
  - A store commits in the REQ cycle where `DC_WR_ACK`=1.
- Outputs at commit:
  - Write enables are active only in the commit cycle: `GPR_WE1 = V & ex_ld_gpr1`, and likewise for GPR2, GPR3, SEG and MM.
  - `EIP`/`CS` take NEIP/NCS.
  - `RETIRE_CNT` increments, wrapping 0xFFFFFFFF→0.
  - EFLAGS is masked by `flags_affected`: bit k of the mask selects EFLAGS position {0:CF, 1:PF, 2:AF, 3:ZF, 4:SF, 5:DF, 6:OF} = bits {0,2,4,6,7,10,11}. Only selected bits take `WB_FLAGS`; all others hold.
- FSM states:
  - IDLE: on latch load of a valid store, go to REQ.
  - REQ: `DC_WR_REQ`=1, `WB_stall`=1. On `DC_WR_ACK`, commit and go to DONE.
  - DONE: `WB_stall`=0, no writes, latch reloads. If the new instruction is a valid store, go to REQ; otherwise go to IDLE.
- `DC_WR_ADDR`, `DC_WR_DATA` and `DC_WR_SIZE` come from ADDRESS, RESULT_A and datasize. They are stable throughout REQ.
- `DC_WR_ACK` is ignored outside REQ.
- `V`=0 means no writes, no request, and no counter or EIP change.

## Timing
- Reset values:
  - All latches 0, including `V`.
  - State IDLE, all WE and `DC_WR_REQ` = 0, `WB_stall`=0.
  - `EFLAGS`=0x00000002, `EIP`=0, `CS`=0, `RETIRE_CNT`=0.
- Non-store: commits in the first cycle after the latch loads (1 cycle in WB).
- Store: REQ lasts at least 1 cycle. With an ack in the first REQ cycle, the instruction occupies WB for 2 cycles (REQ, DONE). Each ack wait cycle adds 1.
- `WB_stall` is a function of registered state only. There is no combinational path from `DC_WR_ACK`.
- RST asserted mid-REQ: `DC_WR_REQ` drops the next cycle, no commit occurs, and the instruction is discarded.

## Configuration
- `WB_FLAGS_FWD_EN` defined:
  - `CF_dataforwarded`/`AF_dataforwarded` select the latched `WB_FLAGS` CF/AF when `V` is set and the matching affected bit is set (this bypasses the pending writeback).
  - Otherwise they select committed `EFLAGS[0]`/`EFLAGS[4]`.
- Undefined: always committed `EFLAGS[0]`/`EFLAGS[4]`.

## Test plan
- Reset: hold RST 2 cycles -> `EFLAGS`=0x2, `EIP`=0, `RETIRE_CNT`=0, all WE=0, `WB_stall`=0.
- ALU op with DR1=3, A=0x12345678, ld_gpr1=1, flags_affected=0x09, FLAGS=0x41 -> one cycle later `GPR_WE1`=1 with DR1=3 and the data. `EFLAGS` becomes 0x43 (CF and ZF set).
- Store with ADDRESS=0x1000, A=0xDEAD, ack after 3 cycles -> `DC_WR_REQ` high for 3 cycles with the address held, `WB_stall` high for 3 cycles, commit on the ack cycle, DONE, next instruction loads.
- Back-to-back stores, ack on the first REQ cycle each -> each store occupies 2 cycles, and `RETIRE_CNT` advances by 2 in 4 cycles.
- RST during REQ -> `DC_WR_REQ` drops, no GPR/EIP update, counter unchanged.
- `WB_FLAGS_FWD_EN` set, pending FLAGS CF=1 with affected[0]=1 and committed CF=0 -> `CF_dataforwarded`=1. With the macro undefined -> 0.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: EX->WB latches, single-cycle retire into GPR/SEG/MMX/EFLAGS/EIP, store sequencing.
// Latency: non-store commits 1 cycle after latch load; store takes REQ (>=1 cycle, until ack) + DONE.
// Backpressure: WB_stall (registered, high only in REQ) freezes the latches; optional WB_FLAGS_FWD_EN.
module writeback_stage (
  input  logic         CLK,
  input  logic         RST,
  // EX->WB latch inputs
  input  logic         WB_V_next,
  input  logic [31:0]  WB_NEIP_next,
  input  logic [15:0]  WB_NCS_next,
  input  logic [127:0] WB_CONTROL_STORE_next,
  input  logic [1:0]   WB_de_datasize_all_next,
  input  logic         WB_ex_ld_gpr1_wb_next,
  input  logic         WB_ex_ld_gpr2_wb_next,
  input  logic         WB_ex_dcache_write_wb_next,
  input  logic [6:0]   WB_de_flags_affected_wb_next,
  input  logic [31:0]  WB_RESULT_A_next,
  input  logic [31:0]  WB_RESULT_B_next,
  input  logic [31:0]  WB_RESULT_C_next,
  input  logic [31:0]  WB_FLAGS_next,
  input  logic [31:0]  WB_ADDRESS_next,
  input  logic [63:0]  WB_RESULT_MM_next,
  input  logic [2:0]   WB_DR1_next,
  input  logic [2:0]   WB_DR2_next,
  input  logic [2:0]   WB_DR3_next,
  // data cache acknowledge
  input  logic         DC_WR_ACK,
  // GPR write ports
  output logic         GPR_WE1,
  output logic         GPR_WE2,
  output logic         GPR_WE3,
  output logic [2:0]   GPR_DR1,
  output logic [2:0]   GPR_DR2,
  output logic [2:0]   GPR_DR3,
  output logic [31:0]  GPR_DATA1,
  output logic [31:0]  GPR_DATA2,
  output logic [31:0]  GPR_DATA3,
  output logic [1:0]   GPR_SIZE,
  // segment write port
  output logic         SEG_WE,
  output logic [2:0]   SEG_DR,
  output logic [15:0]  SEG_DATA,
  // MMX write port
  output logic         MM_WE,
  output logic [2:0]   MM_DR,
  output logic [63:0]  MM_DATA,
  // data cache store request
  output logic         DC_WR_REQ,
  output logic [31:0]  DC_WR_ADDR,
  output logic [31:0]  DC_WR_DATA,
  output logic [1:0]   DC_WR_SIZE,
  // committed architectural state
  output logic [31:0]  EFLAGS,
  output logic [31:0]  EIP,
  output logic [15:0]  CS,
  output logic [31:0]  RETIRE_CNT,
  // back to EX
  output logic         WB_stall,
  output logic         CF_dataforwarded,
  output logic         AF_dataforwarded
);

  // Control-store bit positions for the writeback load enables not carried as separate latches.
  localparam int unsigned CS_LD_GPR3_BIT = 0;
  localparam int unsigned CS_LD_SEG_BIT  = 1;
  localparam int unsigned CS_LD_MM_BIT   = 2;

  localparam logic [31:0] EFLAGS_RESET = 32'h0000_0002;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } wb_state_t;

  wb_state_t r_state;
  wb_state_t w_state_next;

  // EX->WB latches
  logic         r_v;
  logic [31:0]  r_neip;
  logic [15:0]  r_ncs;
  logic [127:0] r_control_store;
  logic [1:0]   r_datasize;
  logic         r_ld_gpr1;
  logic         r_ld_gpr2;
  logic         r_dcache_write;
  logic [6:0]   r_flags_affected;
  logic [31:0]  r_result_a;
  logic [31:0]  r_result_b;
  logic [31:0]  r_result_c;
  logic [31:0]  r_flags;
  logic [31:0]  r_address;
  logic [63:0]  r_result_mm;
  logic [2:0]   r_dr1;
  logic [2:0]   r_dr2;
  logic [2:0]   r_dr3;

  // Committed architectural state
  logic [31:0]  r_eflags;
  logic [31:0]  r_eip;
  logic [15:0]  r_cs;
  logic [31:0]  r_retire_cnt;

  logic         w_stall;
  logic         w_dc_req;
  logic         w_commit;
  logic         w_load;
  logic         w_next_is_store;
  logic         w_cs_ld_gpr3;
  logic         w_cs_ld_seg;
  logic         w_cs_ld_mm;
  logic [31:0]  w_flag_mask;
  logic [31:0]  w_eflags_next;
  logic         w_cf_fwd;
  logic         w_af_fwd;
  logic [124:0] w_cs_unused;

  assign w_load          = ~w_stall;
  assign w_next_is_store = WB_V_next & WB_ex_dcache_write_wb_next;

  // Control-store decode of the remaining writeback enables.
  assign w_cs_ld_gpr3 = r_control_store[CS_LD_GPR3_BIT];
  assign w_cs_ld_seg  = r_control_store[CS_LD_SEG_BIT];
  assign w_cs_ld_mm   = r_control_store[CS_LD_MM_BIT];
  assign w_cs_unused  = r_control_store[127:3];

  // EX->WB latches: load whenever WB is not stalled, hold during a store request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_v              <= 1'b0;
      r_neip           <= '0;
      r_ncs            <= '0;
      r_control_store  <= '0;
      r_datasize       <= '0;
      r_ld_gpr1        <= 1'b0;
      r_ld_gpr2        <= 1'b0;
      r_dcache_write   <= 1'b0;
      r_flags_affected <= '0;
      r_result_a       <= '0;
      r_result_b       <= '0;
      r_result_c       <= '0;
      r_flags          <= '0;
      r_address        <= '0;
      r_result_mm      <= '0;
      r_dr1            <= '0;
      r_dr2            <= '0;
      r_dr3            <= '0;
    end else if (w_load) begin
      r_v              <= WB_V_next;
      r_neip           <= WB_NEIP_next;
      r_ncs            <= WB_NCS_next;
      r_control_store  <= WB_CONTROL_STORE_next;
      r_datasize       <= WB_de_datasize_all_next;
      r_ld_gpr1        <= WB_ex_ld_gpr1_wb_next;
      r_ld_gpr2        <= WB_ex_ld_gpr2_wb_next;
      r_dcache_write   <= WB_ex_dcache_write_wb_next;
      r_flags_affected <= WB_de_flags_affected_wb_next;
      r_result_a       <= WB_RESULT_A_next;
      r_result_b       <= WB_RESULT_B_next;
      r_result_c       <= WB_RESULT_C_next;
      r_flags          <= WB_FLAGS_next;
      r_address        <= WB_ADDRESS_next;
      r_result_mm      <= WB_RESULT_MM_next;
      r_dr1            <= WB_DR1_next;
      r_dr2            <= WB_DR2_next;
      r_dr3            <= WB_DR3_next;
    end
  end

  // Store sequencer state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, commit strobe and handshake outputs; stall depends on registered state only.
  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_stall      = 1'b0;
    w_dc_req     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A latched store always moves straight to REQ, so only non-stores commit here.
        w_commit = r_v & ~r_dcache_write;
        if (w_next_is_store) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        w_stall  = 1'b1;
        w_dc_req = 1'b1;
        if (DC_WR_ACK) begin
          w_commit     = r_v;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        // The retired store is still latched here; it must not write a second time.
        if (w_next_is_store) begin
          w_state_next = S_REQ;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // A reset landing on an ack cycle discards the instruction instead of retiring it.
    if (RST) begin
      w_commit = 1'b0;
    end
  end

  // Map the 7 flags_affected bits onto CF, PF, AF, ZF, SF, DF, OF positions.
  always_comb begin
    w_flag_mask     = '0;
    w_flag_mask[0]  = r_flags_affected[0];
    w_flag_mask[2]  = r_flags_affected[1];
    w_flag_mask[4]  = r_flags_affected[2];
    w_flag_mask[6]  = r_flags_affected[3];
    w_flag_mask[7]  = r_flags_affected[4];
    w_flag_mask[10] = r_flags_affected[5];
    w_flag_mask[11] = r_flags_affected[6];
    w_eflags_next   = (r_eflags & ~w_flag_mask) | (r_flags & w_flag_mask);
  end

  // Architectural state updates on the single commit cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_eflags     <= EFLAGS_RESET;
      r_eip        <= '0;
      r_cs         <= '0;
      r_retire_cnt <= '0;
    end else if (w_commit) begin
      r_eflags     <= w_eflags_next;
      r_eip        <= r_neip;
      r_cs         <= r_ncs;
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

`ifdef WB_FLAGS_FWD_EN
  // Bypass the pending writeback so EX sees CF/AF before they commit.
  assign w_cf_fwd = (r_v & r_flags_affected[0]) ? r_flags[0] : r_eflags[0];
  assign w_af_fwd = (r_v & r_flags_affected[2]) ? r_flags[4] : r_eflags[4];
`else
  assign w_cf_fwd = r_eflags[0];
  assign w_af_fwd = r_eflags[4];
`endif

  // Write ports: enables only in the commit cycle, data straight from the latches.
  assign GPR_WE1   = w_commit & r_ld_gpr1;
  assign GPR_WE2   = w_commit & r_ld_gpr2;
  assign GPR_WE3   = w_commit & w_cs_ld_gpr3;
  assign GPR_DR1   = r_dr1;
  assign GPR_DR2   = r_dr2;
  assign GPR_DR3   = r_dr3;
  assign GPR_DATA1 = r_result_a;
  assign GPR_DATA2 = r_result_b;
  assign GPR_DATA3 = r_result_c;
  assign GPR_SIZE  = r_datasize;

  assign SEG_WE    = w_commit & w_cs_ld_seg;
  assign SEG_DR    = r_dr1;
  assign SEG_DATA  = r_result_a[15:0];

  assign MM_WE     = w_commit & w_cs_ld_mm;
  assign MM_DR     = r_dr1;
  assign MM_DATA   = r_result_mm;

  // Store request fields come from held latches, so they stay stable through REQ.
  assign DC_WR_REQ  = w_dc_req;
  assign DC_WR_ADDR = r_address;
  assign DC_WR_DATA = r_result_a;
  assign DC_WR_SIZE = r_datasize;

  assign EFLAGS     = r_eflags;
  assign EIP        = r_eip;
  assign CS         = r_cs;
  assign RETIRE_CNT = r_retire_cnt;

  assign WB_stall         = w_stall;
  assign CF_dataforwarded = w_cf_fwd;
  assign AF_dataforwarded = w_af_fwd;

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed instructions, write-port and store scoreboards.
// Expected writes/stores are queued at issue; a negedge monitor pops and compares them.
// Architectural state and handshake timing are checked inline against hand-computed values.
module tb_writeback_stage;

  localparam logic [127:0] CS_GPR3 = 128'h1;
  localparam logic [127:0] CS_SEG  = 128'h2;
  localparam logic [127:0] CS_MM   = 128'h4;

`ifdef WB_FLAGS_FWD_EN
  localparam logic EXP_FWD = 1'b1;
`else
  localparam logic EXP_FWD = 1'b0;
`endif

  logic         CLK;
  logic         RST;
  logic         WB_V_next;
  logic [31:0]  WB_NEIP_next;
  logic [15:0]  WB_NCS_next;
  logic [127:0] WB_CONTROL_STORE_next;
  logic [1:0]   WB_de_datasize_all_next;
  logic         WB_ex_ld_gpr1_wb_next;
  logic         WB_ex_ld_gpr2_wb_next;
  logic         WB_ex_dcache_write_wb_next;
  logic [6:0]   WB_de_flags_affected_wb_next;
  logic [31:0]  WB_RESULT_A_next;
  logic [31:0]  WB_RESULT_B_next;
  logic [31:0]  WB_RESULT_C_next;
  logic [31:0]  WB_FLAGS_next;
  logic [31:0]  WB_ADDRESS_next;
  logic [63:0]  WB_RESULT_MM_next;
  logic [2:0]   WB_DR1_next;
  logic [2:0]   WB_DR2_next;
  logic [2:0]   WB_DR3_next;
  logic         DC_WR_ACK;
  logic         GPR_WE1, GPR_WE2, GPR_WE3;
  logic [2:0]   GPR_DR1, GPR_DR2, GPR_DR3;
  logic [31:0]  GPR_DATA1, GPR_DATA2, GPR_DATA3;
  logic [1:0]   GPR_SIZE;
  logic         SEG_WE;
  logic [2:0]   SEG_DR;
  logic [15:0]  SEG_DATA;
  logic         MM_WE;
  logic [2:0]   MM_DR;
  logic [63:0]  MM_DATA;
  logic         DC_WR_REQ;
  logic [31:0]  DC_WR_ADDR;
  logic [31:0]  DC_WR_DATA;
  logic [1:0]   DC_WR_SIZE;
  logic [31:0]  EFLAGS;
  logic [31:0]  EIP;
  logic [15:0]  CS;
  logic [31:0]  RETIRE_CNT;
  logic         WB_stall;
  logic         CF_dataforwarded;
  logic         AF_dataforwarded;

  writeback_stage dut (
    .CLK(CLK), .RST(RST),
    .WB_V_next(WB_V_next), .WB_NEIP_next(WB_NEIP_next), .WB_NCS_next(WB_NCS_next),
    .WB_CONTROL_STORE_next(WB_CONTROL_STORE_next),
    .WB_de_datasize_all_next(WB_de_datasize_all_next),
    .WB_ex_ld_gpr1_wb_next(WB_ex_ld_gpr1_wb_next), .WB_ex_ld_gpr2_wb_next(WB_ex_ld_gpr2_wb_next),
    .WB_ex_dcache_write_wb_next(WB_ex_dcache_write_wb_next),
    .WB_de_flags_affected_wb_next(WB_de_flags_affected_wb_next),
    .WB_RESULT_A_next(WB_RESULT_A_next), .WB_RESULT_B_next(WB_RESULT_B_next),
    .WB_RESULT_C_next(WB_RESULT_C_next), .WB_FLAGS_next(WB_FLAGS_next),
    .WB_ADDRESS_next(WB_ADDRESS_next), .WB_RESULT_MM_next(WB_RESULT_MM_next),
    .WB_DR1_next(WB_DR1_next), .WB_DR2_next(WB_DR2_next), .WB_DR3_next(WB_DR3_next),
    .DC_WR_ACK(DC_WR_ACK),
    .GPR_WE1(GPR_WE1), .GPR_WE2(GPR_WE2), .GPR_WE3(GPR_WE3),
    .GPR_DR1(GPR_DR1), .GPR_DR2(GPR_DR2), .GPR_DR3(GPR_DR3),
    .GPR_DATA1(GPR_DATA1), .GPR_DATA2(GPR_DATA2), .GPR_DATA3(GPR_DATA3), .GPR_SIZE(GPR_SIZE),
    .SEG_WE(SEG_WE), .SEG_DR(SEG_DR), .SEG_DATA(SEG_DATA),
    .MM_WE(MM_WE), .MM_DR(MM_DR), .MM_DATA(MM_DATA),
    .DC_WR_REQ(DC_WR_REQ), .DC_WR_ADDR(DC_WR_ADDR), .DC_WR_DATA(DC_WR_DATA), .DC_WR_SIZE(DC_WR_SIZE),
    .EFLAGS(EFLAGS), .EIP(EIP), .CS(CS), .RETIRE_CNT(RETIRE_CNT),
    .WB_stall(WB_stall), .CF_dataforwarded(CF_dataforwarded), .AF_dataforwarded(AF_dataforwarded)
  );

  typedef struct packed {
    logic [4:0]  we;    // {MM, SEG, GPR3, GPR2, GPR1}
    logic [2:0]  dr1, dr2, dr3;
    logic [31:0] d1, d2, d3;
    logic [1:0]  size;
    logic [15:0] seg;
    logic [63:0] mm;
  } wr_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } st_t;

  wr_t wq[$];
  st_t sq[$];
  int  checks = 0;
  int  errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_next();
    WB_V_next = 0; WB_NEIP_next = '0; WB_NCS_next = '0; WB_CONTROL_STORE_next = '0;
    WB_de_datasize_all_next = '0; WB_ex_ld_gpr1_wb_next = 0; WB_ex_ld_gpr2_wb_next = 0;
    WB_ex_dcache_write_wb_next = 0; WB_de_flags_affected_wb_next = '0;
    WB_RESULT_A_next = '0; WB_RESULT_B_next = '0; WB_RESULT_C_next = '0;
    WB_FLAGS_next = '0; WB_ADDRESS_next = '0; WB_RESULT_MM_next = '0;
    WB_DR1_next = '0; WB_DR2_next = '0; WB_DR3_next = '0;
  endtask

  // Monitor: every write-port strobe and every accepted store must match the next queued expectation.
  always @(negedge CLK) begin
    wr_t e;
    st_t s;
    if (GPR_WE1 | GPR_WE2 | GPR_WE3 | SEG_WE | MM_WE) begin
      if (wq.size() == 0) begin
        chk("unexpected_write_we", 64'({MM_WE, SEG_WE, GPR_WE3, GPR_WE2, GPR_WE1}), 64'd0);
      end else begin
        e = wq.pop_front();
        chk("wr_we", 64'({MM_WE, SEG_WE, GPR_WE3, GPR_WE2, GPR_WE1}), 64'(e.we));
        chk("wr_size", 64'(GPR_SIZE), 64'(e.size));
        if (e.we[0]) begin
          chk("wr_dr1", 64'(GPR_DR1), 64'(e.dr1));
          chk("wr_data1", 64'(GPR_DATA1), 64'(e.d1));
        end
        if (e.we[1]) begin
          chk("wr_dr2", 64'(GPR_DR2), 64'(e.dr2));
          chk("wr_data2", 64'(GPR_DATA2), 64'(e.d2));
        end
        if (e.we[2]) begin
          chk("wr_dr3", 64'(GPR_DR3), 64'(e.dr3));
          chk("wr_data3", 64'(GPR_DATA3), 64'(e.d3));
        end
        if (e.we[3]) begin
          chk("seg_dr", 64'(SEG_DR), 64'(e.dr1));
          chk("seg_data", 64'(SEG_DATA), 64'(e.seg));
        end
        if (e.we[4]) begin
          chk("mm_dr", 64'(MM_DR), 64'(e.dr1));
          chk("mm_data", MM_DATA, e.mm);
        end
      end
    end
    if (DC_WR_REQ && DC_WR_ACK && !RST) begin
      if (sq.size() == 0) begin
        chk("unexpected_store_addr", 64'(DC_WR_ADDR), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        s = sq.pop_front();
        chk("st_addr", 64'(DC_WR_ADDR), 64'(s.addr));
        chk("st_data", 64'(DC_WR_DATA), 64'(s.data));
        chk("st_size", 64'(DC_WR_SIZE), 64'(s.size));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t e;
    st_t s;
    RST = 1'b1;
    DC_WR_ACK = 1'b0;
    clr_next();

    // Reset held for two cycles
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_eflags", 64'(EFLAGS), 64'h2);
    chk("rst_eip", 64'(EIP), 64'h0);
    chk("rst_cs", 64'(CS), 64'h0);
    chk("rst_cnt", 64'(RETIRE_CNT), 64'h0);
    chk("rst_we", 64'({MM_WE, SEG_WE, GPR_WE3, GPR_WE2, GPR_WE1}), 64'h0);
    chk("rst_stall", 64'(WB_stall), 64'h0);
    chk("rst_req", 64'(DC_WR_REQ), 64'h0);

    // Store interrupted by reset while in REQ: discarded, no writes even with ack present
    tick(); clr_next();
    WB_V_next = 1; WB_ex_dcache_write_wb_next = 1; WB_ex_ld_gpr1_wb_next = 1;
    WB_DR1_next = 3'd2; WB_RESULT_A_next = 32'h5A5A; WB_ADDRESS_next = 32'h4000;
    WB_NEIP_next = 32'h600; WB_NCS_next = 16'h20;
    tick(); clr_next();
    @(negedge CLK);
    chk("rstreq_req_before", 64'(DC_WR_REQ), 64'h1);
    chk("rstreq_stall_before", 64'(WB_stall), 64'h1);
    tick(); RST = 1'b1; DC_WR_ACK = 1'b1;
    @(negedge CLK);
    chk("rstreq_req_in_rst_cycle", 64'(DC_WR_REQ), 64'h1);
    tick(); RST = 1'b0; DC_WR_ACK = 1'b0;
    @(negedge CLK);
    chk("rstreq_req_dropped", 64'(DC_WR_REQ), 64'h0);
    chk("rstreq_stall", 64'(WB_stall), 64'h0);
    chk("rstreq_eip", 64'(EIP), 64'h0);
    chk("rstreq_cs", 64'(CS), 64'h0);
    chk("rstreq_cnt", 64'(RETIRE_CNT), 64'h0);

    // ALU op: GPR1 write, CF and ZF committed
    tick(); clr_next();
    WB_V_next = 1; WB_DR1_next = 3'd3; WB_RESULT_A_next = 32'h1234_5678; WB_ex_ld_gpr1_wb_next = 1;
    WB_de_flags_affected_wb_next = 7'h09; WB_FLAGS_next = 32'h41;
    WB_NEIP_next = 32'h100; WB_NCS_next = 16'h8;
    e = '0; e.we = 5'b00001; e.dr1 = 3'd3; e.d1 = 32'h1234_5678; wq.push_back(e);
    tick(); clr_next();
    @(negedge CLK);
    chk("alu1_cf_fwd", 64'(CF_dataforwarded), 64'(EXP_FWD));
    chk("alu1_af_fwd", 64'(AF_dataforwarded), 64'h0);
    chk("alu1_cnt_before", 64'(RETIRE_CNT), 64'h0);
    tick();
    @(negedge CLK);
    chk("alu1_eflags", 64'(EFLAGS), 64'h43);
    chk("alu1_eip", 64'(EIP), 64'h100);
    chk("alu1_cs", 64'(CS), 64'h8);
    chk("alu1_cnt", 64'(RETIRE_CNT), 64'h1);
    chk("alu1_cf_committed", 64'(CF_dataforwarded), 64'h1);

    // GPR2/GPR3/SEG/MM write, every flag selected
    tick(); clr_next();
    WB_V_next = 1; WB_DR1_next = 3'd5; WB_DR2_next = 3'd6; WB_DR3_next = 3'd7;
    WB_RESULT_A_next = 32'hAAAA_5555; WB_RESULT_B_next = 32'h1111_2222; WB_RESULT_C_next = 32'h3333_4444;
    WB_RESULT_MM_next = 64'h0123_4567_89AB_CDEF; WB_CONTROL_STORE_next = CS_GPR3 | CS_SEG | CS_MM;
    WB_ex_ld_gpr2_wb_next = 1; WB_de_datasize_all_next = 2'd1;
    WB_de_flags_affected_wb_next = 7'h7F; WB_FLAGS_next = 32'hFFFF_FFFF;
    WB_NEIP_next = 32'h110; WB_NCS_next = 16'h8;
    e = '0; e.we = 5'b11110; e.dr1 = 3'd5; e.dr2 = 3'd6; e.dr3 = 3'd7;
    e.d2 = 32'h1111_2222; e.d3 = 32'h3333_4444; e.size = 2'd1; e.seg = 16'h5555;
    e.mm = 64'h0123_4567_89AB_CDEF; wq.push_back(e);
    tick(); clr_next();
    @(negedge CLK);
    chk("alu2_af_fwd", 64'(AF_dataforwarded), 64'(EXP_FWD));
    tick();
    @(negedge CLK);
    chk("alu2_eflags", 64'(EFLAGS), 64'hCD7);
    chk("alu2_cnt", 64'(RETIRE_CNT), 64'h2);
    chk("alu2_eip", 64'(EIP), 64'h110);

    // Invalid latch: nothing changes
    tick(); clr_next();
    WB_V_next = 0; WB_ex_ld_gpr1_wb_next = 1; WB_de_flags_affected_wb_next = 7'h7F;
    WB_NEIP_next = 32'hBAD; WB_CONTROL_STORE_next = CS_MM;
    tick(); clr_next();
    tick();
    @(negedge CLK);
    chk("bubble_eflags", 64'(EFLAGS), 64'hCD7);
    chk("bubble_cnt", 64'(RETIRE_CNT), 64'h2);
    chk("bubble_eip", 64'(EIP), 64'h110);

    // Clear only CF; other flags hold
    tick(); clr_next();
    WB_V_next = 1; WB_de_flags_affected_wb_next = 7'h01; WB_FLAGS_next = 32'h0;
    WB_NEIP_next = 32'h120; WB_NCS_next = 16'h8;
    tick(); clr_next();
    tick();
    @(negedge CLK);
    chk("clrcf_eflags", 64'(EFLAGS), 64'hCD6);
    chk("clrcf_cnt", 64'(RETIRE_CNT), 64'h3);
    chk("clrcf_eip", 64'(EIP), 64'h120);

    // Store acked in its third REQ cycle, followed by an ALU op held off until DONE
    tick(); clr_next();
    WB_V_next = 1; WB_ex_dcache_write_wb_next = 1; WB_ADDRESS_next = 32'h1000;
    WB_RESULT_A_next = 32'hDEAD; WB_de_datasize_all_next = 2'd2;
    WB_NEIP_next = 32'h200; WB_NCS_next = 16'h10;
    s.addr = 32'h1000; s.data = 32'hDEAD; s.size = 2'd2; sq.push_back(s);
    tick(); clr_next();
    WB_V_next = 1; WB_DR1_next = 3'd1; WB_RESULT_A_next = 32'hCAFE_F00D; WB_ex_ld_gpr1_wb_next = 1;
    WB_NEIP_next = 32'h300; WB_NCS_next = 16'h10;
    e = '0; e.we = 5'b00001; e.dr1 = 3'd1; e.d1 = 32'hCAFE_F00D; wq.push_back(e);
    for (int k = 0; k < 3; k++) begin
      DC_WR_ACK = (k == 2);
      @(negedge CLK);
      chk("st_req_held", 64'(DC_WR_REQ), 64'h1);
      chk("st_stall_held", 64'(WB_stall), 64'h1);
      chk("st_addr_held", 64'(DC_WR_ADDR), 64'h1000);
      chk("st_cnt_wait", 64'(RETIRE_CNT), 64'h3);
      tick();
    end
    // DONE: ack left high to show it is ignored outside REQ
    @(negedge CLK);
    chk("st_done_req", 64'(DC_WR_REQ), 64'h0);
    chk("st_done_stall", 64'(WB_stall), 64'h0);
    chk("st_done_cnt", 64'(RETIRE_CNT), 64'h4);
    chk("st_done_eip", 64'(EIP), 64'h200);
    chk("st_done_cs", 64'(CS), 64'h10);
    tick(); DC_WR_ACK = 1'b0; clr_next();
    tick();
    @(negedge CLK);
    chk("after_st_cnt", 64'(RETIRE_CNT), 64'h5);
    chk("after_st_eip", 64'(EIP), 64'h300);

    // Back-to-back stores, each acked in its first REQ cycle: 2 cycles each
    tick(); clr_next();
    WB_V_next = 1; WB_ex_dcache_write_wb_next = 1; WB_ADDRESS_next = 32'h2000;
    WB_RESULT_A_next = 32'h11; WB_NEIP_next = 32'h400; WB_NCS_next = 16'h10;
    DC_WR_ACK = 1'b1;
    s.addr = 32'h2000; s.data = 32'h11; s.size = 2'd0; sq.push_back(s);
    tick(); clr_next();
    WB_V_next = 1; WB_ex_dcache_write_wb_next = 1; WB_ADDRESS_next = 32'h3000;
    WB_RESULT_A_next = 32'h22; WB_de_datasize_all_next = 2'd1; WB_NEIP_next = 32'h500; WB_NCS_next = 16'h10;
    s.addr = 32'h3000; s.data = 32'h22; s.size = 2'd1; sq.push_back(s);
    @(negedge CLK);
    chk("b2b_req1", 64'(DC_WR_REQ), 64'h1);
    tick();
    @(negedge CLK);
    chk("b2b_done1_req", 64'(DC_WR_REQ), 64'h0);
    chk("b2b_done1_cnt", 64'(RETIRE_CNT), 64'h6);
    chk("b2b_done1_eip", 64'(EIP), 64'h400);
    tick(); clr_next();
    @(negedge CLK);
    chk("b2b_req2", 64'(DC_WR_REQ), 64'h1);
    tick(); DC_WR_ACK = 1'b0;
    @(negedge CLK);
    chk("b2b_done2_req", 64'(DC_WR_REQ), 64'h0);
    chk("b2b_done2_cnt", 64'(RETIRE_CNT), 64'h7);
    chk("b2b_done2_eip", 64'(EIP), 64'h500);

    repeat (3) tick();
    @(negedge CLK);
    chk("write_queue_drained", 64'(wq.size()), 64'h0);
    chk("store_queue_drained", 64'(sq.size()), 64'h0);
    chk("final_cnt", 64'(RETIRE_CNT), 64'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
